// File: rtl/led_pwm_driver.sv
// Four-channel LED PWM dimmer with an Avalon-MM register slave, frame-synchronised duty reload and optional blink.
// Optional blink logic is built only when LED_PWM_DRIVER_BLINK_EN is defined.
module led_pwm_driver #(
  parameter int PRESCALE = 50
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [3:0]  led_in,
  output logic [3:0]  led_out
);

  localparam logic [15:0] PRESCALE_LAST = 16'(PRESCALE - 1);

  typedef enum logic [1:0] {
    ADDR_DUTY   = 2'd0,
    ADDR_CTRL   = 2'd1,
    ADDR_BLINK  = 2'd2,
    ADDR_STATUS = 2'd3
  } reg_addr_e;

  reg_addr_e   reg_addr;
  logic        wr_en;
  logic        wr_duty;
  logic        wr_ctrl;
  logic        wr_blink;

  logic [31:0] duty_shadow;
  logic [31:0] duty_active;
  logic        enable;
  logic [15:0] presc_cnt;
  logic [7:0]  pwm_cnt;
  logic        tick;
  logic        frame_end;
  logic [3:0]  blink_mask;
  logic [15:0] blink_period;
  logic        blink_phase;
  logic [3:0]  led_on;

  assign reg_addr  = reg_addr_e'(address);
  assign wr_en     = chipselect & ~write_n;
  assign wr_duty   = wr_en && (reg_addr == ADDR_DUTY);
  assign wr_ctrl   = wr_en && (reg_addr == ADDR_CTRL);
  assign wr_blink  = wr_en && (reg_addr == ADDR_BLINK);

  assign tick      = enable && (presc_cnt == PRESCALE_LAST);
  assign frame_end = tick && (pwm_cnt == 8'hFF);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      duty_shadow <= '0;
      enable      <= 1'b0;
    end else begin
      if (wr_duty) duty_shadow <= writedata;
      if (wr_ctrl) enable      <= writedata[0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_cnt <= '0;
      pwm_cnt   <= '0;
    end else if (!enable) begin
      presc_cnt <= '0;
      pwm_cnt   <= '0;
    end else if (tick) begin
      presc_cnt <= '0;
      pwm_cnt   <= pwm_cnt + 8'd1;
    end else begin
      presc_cnt <= presc_cnt + 16'd1;
    end
  end

  // The boundary samples the shadow before a coincident write lands, so that write waits one more frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      duty_active <= '0;
    end else if (!enable || frame_end) begin
      duty_active <= duty_shadow;
    end
  end

`ifdef LED_PWM_DRIVER_BLINK_EN
  logic [15:0] blink_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_mask   <= '0;
      blink_period <= '0;
    end else begin
      if (wr_ctrl)  blink_mask   <= writedata[7:4];
      if (wr_blink) blink_period <= writedata[15:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (!enable || (blink_period == 16'd0) || wr_blink) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_end) begin
      if (blink_cnt == blink_period - 16'd1) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 16'd1;
      end
    end
  end
`else
  assign blink_mask   = '0;
  assign blink_period = '0;
  assign blink_phase  = 1'b0;
`endif

  // NOTE: combinational blocks assign a default first so no path can infer a latch.
  always_comb begin
    led_on = '0;
    for (int i = 0; i < 4; i++) begin
      led_on[i] = enable && led_in[i]
                  && ((duty_active[8*i +: 8] == 8'hFF) || (pwm_cnt < duty_active[8*i +: 8]))
                  && !(blink_mask[i] && blink_phase);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) led_out <= '0;
    else          led_out <= led_on;
  end

  always_comb begin
    readdata = '0;
    case (reg_addr)
      ADDR_DUTY:   readdata = duty_shadow;
      ADDR_CTRL:   readdata = {24'd0, blink_mask, 3'd0, enable};
      ADDR_BLINK:  readdata = {16'd0, blink_period};
      ADDR_STATUS: readdata = {23'd0, blink_phase, pwm_cnt};
      default:     readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_led_pwm_driver.sv
// Directed bench for led_pwm_driver at PRESCALE=2 (512-cycle PWM frames): register vectors plus frame-level sequences.
module tb_led_pwm_driver;

  localparam int PRESCALE = 2;
`ifdef LED_PWM_DRIVER_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  led_in;
  logic [3:0]  led_out;

  led_pwm_driver #(.PRESCALE(PRESCALE)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .led_in     (led_in),
    .led_out    (led_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        cs;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } reg_vec_t;

  reg_vec_t vecs[13];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Called in the low clock phase; the write lands on the next rising edge.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; address = 2'd3;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  // Returns at the falling edge of the first cycle of a new frame (pwm_cnt just wrapped 255 -> 0).
  task automatic sync_frame();
    logic [7:0] prev, cur;
    bit found;
    found = 1'b0;
    address = 2'd3;
    #1;
    prev = readdata[7:0];
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      cur = readdata[7:0];
      if (prev == 8'hFF && cur == 8'h00) found = 1'b1;
      prev = cur;
    end
    check("frame_sync", {31'd0, found}, 32'd1);
  endtask

  // Counts led_out[0] high cycles over one frame; optionally writes DUTY on the edge ending cycle write_at.
  task automatic count_frame(input int write_at, input logic [31:0] wdata, output int cnt);
    cnt = 0;
    for (int i = 0; i < 512; i++) begin
      if (i == write_at) begin
        address = 2'd0; writedata = wdata; chipselect = 1'b1; write_n = 1'b0;
      end
      @(negedge clk);
      if (i == write_at) begin
        chipselect = 1'b0; write_n = 1'b1; address = 2'd3;
      end
      cnt += int'(led_out[0]);
    end
  endtask

  initial begin
    int          cnt;
    logic [31:0] d;
    int          exp_cnt[4];
    logic        exp_ph[4];

    vecs[0]  = '{1'b1, 1'b0, 2'd0, 32'h0,        32'h0};
    vecs[1]  = '{1'b1, 1'b0, 2'd1, 32'h0,        32'h0};
    vecs[2]  = '{1'b1, 1'b0, 2'd2, 32'h0,        32'h0};
    vecs[3]  = '{1'b1, 1'b0, 2'd3, 32'h0,        32'h0};
    vecs[4]  = '{1'b1, 1'b1, 2'd0, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[5]  = '{1'b1, 1'b1, 2'd1, 32'hFFFFFFFE, BLINK ? 32'h000000F0 : 32'h0};
    vecs[6]  = '{1'b1, 1'b1, 2'd2, 32'hABCD1234, BLINK ? 32'h00001234 : 32'h0};
    vecs[7]  = '{1'b1, 1'b1, 2'd3, 32'hFFFFFFFF, 32'h0};
    vecs[8]  = '{1'b1, 1'b0, 2'd0, 32'h0,        32'hDEADBEEF};
    vecs[9]  = '{1'b0, 1'b1, 2'd0, 32'h12345678, 32'hDEADBEEF};
    vecs[10] = '{1'b1, 1'b1, 2'd1, 32'h0,        32'h0};
    vecs[11] = '{1'b1, 1'b1, 2'd2, 32'h0,        32'h0};
    vecs[12] = '{1'b1, 1'b0, 2'd3, 32'h0,        32'h0};

    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    address = 2'd0; writedata = '0; led_in = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    check("led_after_reset", {28'd0, led_out}, 32'h0);

    // Register map with the PWM disabled.
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].we) begin
        address = vecs[i].addr; writedata = vecs[i].wdata;
        chipselect = vecs[i].cs; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
      end
      rd(vecs[i].addr, d);
      check($sformatf("regvec%0d", i), d, vecs[i].exp);
    end

    // Full-on and forced-off duty.
    led_in = 4'b0001;
    wr(2'd0, 32'h000000FF);
    wr(2'd1, 32'h1);
    sync_frame();
    count_frame(-1, 32'h0, cnt);
    check("duty_ff_high", cnt, 512);
    check("duty_ff_pins", {28'd0, led_out}, 32'h1);

    wr(2'd1, 32'h0);
    wr(2'd0, 32'h0);
    wr(2'd1, 32'h1);
    sync_frame();
    count_frame(-1, 32'h0, cnt);
    check("duty_00_high", cnt, 0);

    // Duty 0x40, then mid-frame and boundary-coincident DUTY writes.
    wr(2'd1, 32'h0);
    wr(2'd0, 32'h40);
    wr(2'd1, 32'h1);
    sync_frame();
    count_frame(-1, 32'h0, cnt);
    check("duty_40_high", cnt, 128);
    count_frame(100, 32'h80, cnt);
    check("midframe_write_cur", cnt, 128);
    count_frame(-1, 32'h0, cnt);
    check("midframe_write_next", cnt, 256);
    count_frame(511, 32'h20, cnt);
    check("boundary_write_cur", cnt, 256);
    count_frame(-1, 32'h0, cnt);
    check("boundary_write_next", cnt, 256);
    count_frame(-1, 32'h0, cnt);
    check("boundary_write_after", cnt, 64);

    // led_in passes through with one cycle of latency, independent of frames.
    wr(2'd1, 32'h0);
    wr(2'd0, 32'hFFFFFFFF);
    led_in = 4'b1010;
    wr(2'd1, 32'h1);
    @(negedge clk);
    check("led_in_1010", {28'd0, led_out}, 32'hA);
    led_in = 4'b0101;
    @(negedge clk);
    check("led_in_0101", {28'd0, led_out}, 32'h5);

    // Disable mid-frame, then re-enable and watch pwm_cnt restart.
    repeat (300) @(negedge clk);
    wr(2'd1, 32'h0);
    @(negedge clk);
    check("disable_led", {28'd0, led_out}, 32'h0);
    rd(2'd3, d);
    check("disable_status", d, 32'h0);
    wr(2'd1, 32'h1);
    rd(2'd3, d);
    check("reenable_status_c0", d, 32'h0);
    @(negedge clk);
    rd(2'd3, d);
    check("reenable_status_c1", d, 32'h0);
    @(negedge clk);
    rd(2'd3, d);
    check("reenable_status_c2", d, 32'h1);

    // Blink: period 2 frames, LED0 masked, full-on duty.
    exp_cnt = BLINK ? '{512, 0, 0, 512} : '{512, 512, 512, 512};
    exp_ph  = BLINK ? '{1'b1, 1'b1, 1'b0, 1'b0} : '{1'b0, 1'b0, 1'b0, 1'b0};
    wr(2'd1, 32'h0);
    led_in = 4'b0001;
    wr(2'd0, 32'h000000FF);
    wr(2'd2, 32'h2);
    wr(2'd1, 32'h11);
    sync_frame();
    rd(2'd3, d);
    check("blink_phase_start", {31'd0, d[8]}, 32'h0);
    for (int f = 0; f < 4; f++) begin
      count_frame(-1, 32'h0, cnt);
      check($sformatf("blink_frame%0d_high", f), cnt, exp_cnt[f]);
      rd(2'd3, d);
      check($sformatf("blink_frame%0d_phase", f), {31'd0, d[8]}, {31'd0, exp_ph[f]});
    end

    // Asynchronous reset mid-run: outputs clear before any clock edge.
    check("led_before_reset", {28'd0, led_out}, 32'h1);
    reset_n = 1'b0;
    rd(2'd0, d);
    check("async_rst_duty", d, 32'h0);
    rd(2'd1, d);
    check("async_rst_ctrl", d, 32'h0);
    rd(2'd2, d);
    check("async_rst_blink", d, 32'h0);
    rd(2'd3, d);
    check("async_rst_status", d, 32'h0);
    check("async_rst_led", {28'd0, led_out}, 32'h0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_reset_idle_led", {28'd0, led_out}, 32'h0);
    rd(2'd3, d);
    check("post_reset_idle_status", d, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
